// File: rtl/servo_move_sched_if.sv
// Requester handshakes and PWM-side outputs of the servo move scheduler.
interface servo_move_sched_if #(
  parameter int PW_W = 20
);
  logic            req0_valid;
  logic [7:0]      req0_pos;
  logic            req0_ready;
  logic            req1_valid;
  logic [7:0]      req1_pos;
  logic            req1_ready;
  logic [PW_W-1:0] pw_cyc;
  logic            pw_load;
  logic            frame_tick;
  logic            busy;
  logic            done;
  logic            done_id;

  // requesters / observers
  modport master (
    output req0_valid, req0_pos, req1_valid, req1_pos,
    input  req0_ready, req1_ready, pw_cyc, pw_load, frame_tick, busy, done, done_id
  );

  // scheduler
  modport slave (
    input  req0_valid, req0_pos, req1_valid, req1_pos,
    output req0_ready, req1_ready, pw_cyc, pw_load, frame_tick, busy, done, done_id
  );
endinterface

// File: rtl/servo_move_sched.sv
// Servo motion scheduler: arbitrates two move requesters (manual wins), turns an
// 8-bit position into a pulse width and slews toward it by at most STEP per frame.
module servo_move_sched #(
  parameter int FRAME_CYC   = 1_000_000,
  parameter int MIN_PW      = 50_000,
  parameter int MAX_PW      = 100_000,
  parameter int PW_PER_LSB  = 196,
  parameter int STEP        = 500,
  parameter int HOLD_FRAMES = 2,
  parameter int PW_W        = 20
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic               main_program,
  servo_move_sched_if.slave  bus
);

  localparam int CW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [PW_W-1:0] PW_RST  = PW_W'((MIN_PW + MAX_PW) / 2);
  localparam logic [PW_W-1:0] PW_STEP = PW_W'(STEP);
  localparam logic [CW-1:0]   CNT_END = CW'(FRAME_CYC - 1);

  typedef enum logic [1:0] {ST_DIS, ST_RDY, ST_MOV, ST_HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW_W-1:0] pw_q, pw_d, tgt_q, tgt_d, new_tgt, diff;
  logic [HW-1:0]   hold_q, hold_d;
  logic            owner_q, owner_d;
  logic            done_q, done_d;
  logic            pw_load_q;
  logic            tick, rdy, acc0, acc1;
  logic [7:0]      acc_pos;
  logic [16:0]     prod;

  // Handshake and frame strobe; disabling takes priority over any accept
  always_comb begin
    rdy     = (state_q == ST_RDY) && main_program;
    acc1    = rdy && bus.req1_valid;
    acc0    = rdy && bus.req0_valid && !bus.req1_valid;
    tick    = (state_q != ST_DIS) && main_program && (cnt_q == CNT_END);
    acc_pos = acc1 ? bus.req1_pos : bus.req0_pos;
    prod    = 17'(acc_pos) * 17'(PW_PER_LSB);
    new_tgt = PW_W'(MIN_PW) + PW_W'(prod);
    diff    = (tgt_q >= pw_q) ? (tgt_q - pw_q) : (pw_q - tgt_q);
  end

  // Next-state, slew and hold logic
  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    owner_d = owner_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_DIS: state_d = ST_RDY;
      ST_RDY: begin
        if (acc0 || acc1) begin
          tgt_d   = new_tgt;
          owner_d = acc1;
          state_d = ST_MOV;
        end
      end
      ST_MOV: begin
        if (tick) begin
          if (diff <= PW_STEP) begin
            pw_d    = tgt_q;
            hold_d  = HW'(HOLD_FRAMES);
            state_d = ST_HOLD;
          end else if (tgt_q > pw_q) begin
            pw_d = pw_q + PW_STEP;
          end else begin
            pw_d = pw_q - PW_STEP;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HW'(1)) begin
            done_d  = 1'b1;
            state_d = ST_RDY;
          end
        end
      end
      default: state_d = ST_DIS;
    endcase
    // frame counter restarts from 0 whenever the scheduler is (re)enabled
    if (state_q == ST_DIS || cnt_q == CNT_END) cnt_d = '0;
    else                                       cnt_d = cnt_q + 1'b1;
    // disable aborts any move: width frozen, target snaps to it, no done
    if (!main_program) begin
      state_d = ST_DIS;
      tgt_d   = pw_q;
      hold_d  = '0;
      done_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  // State register; pw_load trails frame_tick by one cycle so pw_cyc is already new
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_DIS;
      cnt_q     <= '0;
      pw_q      <= PW_RST;
      tgt_q     <= PW_RST;
      hold_q    <= '0;
      owner_q   <= 1'b0;
      done_q    <= 1'b0;
      pw_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pw_q      <= pw_d;
      tgt_q     <= tgt_d;
      hold_q    <= hold_d;
      owner_q   <= owner_d;
      done_q    <= done_d;
      pw_load_q <= tick;
    end
  end

  assign bus.req1_ready = rdy;
  assign bus.req0_ready = rdy && !bus.req1_valid;
  assign bus.pw_cyc     = pw_q;
  assign bus.pw_load    = pw_load_q;
  assign bus.frame_tick = tick;
  assign bus.busy       = (state_q == ST_MOV) || (state_q == ST_HOLD);
  assign bus.done       = done_q;
  assign bus.done_id    = owner_q;

endmodule

// File: tb/tb_servo_move_sched.sv
// Randomized bench for servo_move_sched with a frame-level model of each move.
module tb_servo_move_sched;
  localparam int FR    = 100;
  localparam int MINP  = 50_000;
  localparam int LSB   = 196;
  localparam int STEP  = 500;
  localparam int HOLD  = 2;
  localparam int RSTPW = 75_000;

  logic mclk = 1'b0, reset = 1'b0, main_program = 1'b0;
  int   total = 0, bad = 0;
  int   cur_pw;
  int   last_f;

  servo_move_sched_if #(.PW_W(20)) bus();

  servo_move_sched #(.FRAME_CYC(FR)) dut (
    .mclk(mclk), .reset(reset), .main_program(main_program), .bus(bus)
  );

  always #5 mclk = ~mclk;

  initial begin
    #990_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Follow one accepted move frame by frame: expected width per pw_load comes
  // from the slew rule, done expected HOLD frames after the target is reached.
  task automatic track_move(input int id, input int pos, input bit skip, input int abort_pw);
    int tgt, mpw, reached, f, n, d, ad;
    bit sk;
    tgt = MINP + pos * LSB; mpw = cur_pw; reached = -1; f = 0; sk = skip;
    while (f < 400) begin
      n = 0;
      do begin @(negedge mclk); n++; end while (!bus.pw_load && n < 2 * FR);
      if (!bus.pw_load) begin chk("pw_load_seen", 0, 1); break; end
      if (sk) begin sk = 0; chk("pw_unchanged", bus.pw_cyc, mpw); continue; end
      f++;
      if (reached < 0) begin
        d  = tgt - mpw;
        ad = (d < 0) ? -d : d;
        if (ad <= STEP) begin mpw = tgt; reached = f; end
        else mpw += (d > 0) ? STEP : -STEP;
      end
      chk("pw_step", bus.pw_cyc, mpw);
      cur_pw = mpw;
      last_f = f;
      if (abort_pw >= 0 && mpw == abort_pw) break;
      if (reached >= 0 && f == reached + HOLD) begin
        chk("done", bus.done, 1);
        chk("done_id", bus.done_id, id);
        chk("busy_after_done", bus.busy, 0);
        break;
      end
      chk("done_early", bus.done, 0);
      chk("busy", bus.busy, 1);
    end
  endtask

  task automatic request(input int id, input int pos, input int abort_pw);
    int n;
    bit sk, rdy;
    n = 0;
    @(posedge mclk); #1;
    if (id == 1) begin bus.req1_valid = 1; bus.req1_pos = 8'(pos); end
    else         begin bus.req0_valid = 1; bus.req0_pos = 8'(pos); end
    do begin
      @(negedge mclk); n++;
      rdy = (id == 1) ? bus.req1_ready : bus.req0_ready;
    end while (!rdy && n < 20);
    chk("accept", int'(rdy), 1);
    sk = bus.frame_tick;
    @(posedge mclk); #1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    track_move(id, pos, sk, abort_pw);
  endtask

  // Cycles from raising main_program until the first frame_tick
  task automatic count_to_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge mclk); @(negedge mclk); n++;
      if (n == 1) chk({tag, "_ready1"}, bus.req1_ready, 1);
    end while (!bus.frame_tick && n < 3 * FR);
    chk({tag, "_tick_cyc"}, n, FR);
  endtask

  initial begin
    int a, b, viol, pos;
    bit sk;
    bus.req0_valid = 0; bus.req0_pos = 0; bus.req1_valid = 0; bus.req1_pos = 0;

    // reset values
    #12;
    chk("rst_pw", bus.pw_cyc, RSTPW);
    chk("rst_flags", {bus.pw_load, bus.frame_tick, bus.busy, bus.done, bus.done_id,
                      bus.req0_ready, bus.req1_ready}, 0);

    // enable: first frame, pw_load carries the reset width
    @(posedge mclk); #1 reset = 1;
    @(posedge mclk); #1 main_program = 1;
    count_to_tick("en");
    @(negedge mclk);
    chk("first_pw_load", bus.pw_load, 1);
    chk("first_pw", bus.pw_cyc, RSTPW);
    cur_pw = RSTPW;

    // full-scale ramp up
    request(0, 255, -1);
    chk("ramp_frames", last_f, 52);
    chk("ramp_final", cur_pw, 99_980);

    // ramp down to pos 0, then pos 0 again goes straight to HOLD
    request(1, 0, -1);
    request(0, 0, -1);
    chk("zero_move_frames", last_f, 1 + HOLD);

    // abort mid-move at 80_000
    request(0, 255, 80_000);
    @(posedge mclk); #1 main_program = 0;
    viol = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge mclk);
      if (i > 0 && (bus.frame_tick || bus.pw_load || bus.done || bus.busy ||
                    bus.req1_ready || bus.pw_cyc != 80_000)) viol++;
    end
    chk("disabled_quiet", viol, 0);
    @(posedge mclk); #1 main_program = 1;
    count_to_tick("reen");
    @(negedge mclk);
    chk("reen_pw", bus.pw_cyc, 80_000);
    cur_pw = 80_000;

    // simultaneous requests: manual first, program held and taken after done
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    @(posedge mclk); #1;
    bus.req0_valid = 1; bus.req0_pos = 8'(a);
    bus.req1_valid = 1; bus.req1_pos = 8'(b);
    @(negedge mclk);
    chk("prio_r1", bus.req1_ready, 1);
    chk("prio_r0", bus.req0_ready, 0);
    sk = bus.frame_tick;
    @(posedge mclk); #1 bus.req1_valid = 0;
    track_move(1, b, sk, -1);
    chk("r0_ready_at_done", bus.req0_ready, 1);
    sk = bus.frame_tick;
    @(posedge mclk); #1 bus.req0_valid = 0;
    track_move(0, a, sk, -1);

    // random moves
    for (int k = 0; k < 2; k++)
      request(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), -1);

    // async reset while holding
    pos = $urandom_range(0, 255);
    request(1, pos, MINP + pos * LSB);
    chk("in_hold_busy", bus.busy, 1);
    #2 reset = 0;
    #1;
    chk("arst_pw", bus.pw_cyc, RSTPW);
    chk("arst_flags", {bus.pw_load, bus.frame_tick, bus.busy, bus.done, bus.done_id,
                       bus.req0_ready, bus.req1_ready}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
